// File: rtl/apb_multi_decoder.sv
// APB address decoder and response mux: one master, NUM_SLAVES fixed-size slots.
// Produces its own error response for unmapped, timed-out and malformed transfers and records them.
module apb_multi_decoder #(
    parameter int                NUM_SLAVES = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'('h1000),
    parameter int                SLOT_BITS  = 12,
    parameter int                TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_SLAVES-1:0]        PSEL_S,
    output logic                         PENABLE_S,
    output logic                         PWRITE_S,
    output logic [ADDR_W-1:0]            PADDR_S,
    output logic [DATA_W-1:0]            PWDATA_S,
    output logic [DATA_W/8-1:0]          PSTRB_S,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_S,
    input  logic [NUM_SLAVES-1:0]        PREADY_S,
    input  logic [NUM_SLAVES-1:0]        PSLVERR_S,
    output logic                         err_pulse,
    output logic [1:0]                   err_cause,
    output logic [7:0]                   err_count,
    output logic [ADDR_W-1:0]            last_err_addr
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_PROTOCOL = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;
    logic              mapped_q, mapped_nxt;
    logic [15:0]       wait_cnt, wait_nxt;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] slot_num;
    logic              dec_mapped;
    logic [SEL_W-1:0]  dec_idx;
    logic [DATA_W-1:0] slot_rdata;
    logic              slot_ready;
    logic              slot_err;

    logic              err_now;
    logic [1:0]        err_code;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Shared signals go straight through; only PSEL is decoded.
    assign PENABLE_S = PENABLE;
    assign PWRITE_S  = PWRITE;
    assign PADDR_S   = PADDR;
    assign PWDATA_S  = PWDATA;
    assign PSTRB_S   = PSTRB;

    assign offset     = PADDR - BASE_ADDR;
    assign slot_num   = offset >> SLOT_BITS;
    assign dec_mapped = (PADDR >= BASE_ADDR) && (slot_num < ADDR_W'(NUM_SLAVES));
    assign dec_idx    = slot_num[SEL_W-1:0];

    assign slot_rdata = PRDATA_S[int'(sel_q) * DATA_W +: DATA_W];
    assign slot_ready = PREADY_S[sel_q];
    assign slot_err   = PSLVERR_S[sel_q];

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel_q;
        mapped_nxt = mapped_q;
        wait_nxt   = wait_cnt;
        PSEL_S     = '0;
        PRDATA     = '0;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
        err_now    = 1'b0;
        err_code   = CAUSE_NONE;

        unique case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    if (dec_mapped) begin
                        PSEL_S[dec_idx] = 1'b1;
                    end
                    sel_nxt    = dec_mapped ? dec_idx : '0;
                    mapped_nxt = dec_mapped;
                    wait_nxt   = '0;
                    state_nxt  = ACCESS;
                end else if (PSEL && PENABLE) begin
                    // ACCESS phase without a preceding SETUP: answer it ourselves.
                    PREADY   = 1'b1;
                    PSLVERR  = 1'b1;
                    err_now  = 1'b1;
                    err_code = CAUSE_PROTOCOL;
                end
            end

            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else begin
                    if (mapped_q) begin
                        PSEL_S[sel_q] = 1'b1;
                    end
                    if (PENABLE) begin
                        if (!mapped_q) begin
                            PREADY    = 1'b1;
                            PSLVERR   = 1'b1;
                            err_now   = 1'b1;
                            err_code  = CAUSE_UNMAPPED;
                            state_nxt = IDLE;
                        end else if (slot_ready) begin
                            // A slave answering on the timeout cycle still wins.
                            PREADY    = 1'b1;
                            PSLVERR   = slot_err;
                            PRDATA    = slot_rdata;
                            state_nxt = IDLE;
                        end else if (wait_cnt == 16'(TIMEOUT)) begin
                            PREADY    = 1'b1;
                            PSLVERR   = 1'b1;
                            err_now   = 1'b1;
                            err_code  = CAUSE_TIMEOUT;
                            state_nxt = IDLE;
                        end else begin
                            wait_nxt = wait_cnt + 16'd1;
                        end
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase

        // Nothing reaches slaves or master while reset is held.
        if (!rst) begin
            PSEL_S  = '0;
            PRDATA  = '0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            err_now = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            sel_q         <= '0;
            mapped_q      <= 1'b0;
            wait_cnt      <= '0;
            err_pulse     <= 1'b0;
            err_cause     <= CAUSE_NONE;
            err_count     <= '0;
            last_err_addr <= '0;
        end else begin
            state     <= state_nxt;
            sel_q     <= sel_nxt;
            mapped_q  <= mapped_nxt;
            wait_cnt  <= wait_nxt;
            err_pulse <= err_now;
            if (err_now) begin
                err_cause     <= err_code;
                err_count     <= sat_inc8(err_count);
                last_err_addr <= PADDR;
            end
        end
    end

endmodule

// File: tb/tb_apb_multi_decoder.sv
// Directed bench for apb_multi_decoder with a transfer-level reference model checked every cycle.
module tb_apb_multi_decoder;

    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0]  paddr = '0;
    logic [DW-1:0]  pwdata = '0;
    logic [3:0]     pstrb = '0;
    logic [DW-1:0]  prdata_o;
    logic           pready_o, pslverr_o;
    logic [NS-1:0]  psel_s_o;
    logic           penable_s_o, pwrite_s_o;
    logic [AW-1:0]  paddr_s_o;
    logic [DW-1:0]  pwdata_s_o;
    logic [3:0]     pstrb_s_o;
    logic [NS*DW-1:0] prdata_s = {32'h33330003, 32'hDEADBEEF, 32'h11110001, 32'h00A500A5};
    logic [NS-1:0]  pready_s = '0;
    logic [NS-1:0]  pslverr_s = '0;
    logic           err_pulse_o;
    logic [1:0]     err_cause_o;
    logic [7:0]     err_count_o;
    logic [AW-1:0]  last_err_addr_o;

    int n_pass = 0;
    int n_total = 0;
    bit checking = 1'b0;

    apb_multi_decoder #(
        .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .BASE_ADDR(32'h1000), .SLOT_BITS(12), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
        .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata_o), .PREADY(pready_o), .PSLVERR(pslverr_o),
        .PSEL_S(psel_s_o), .PENABLE_S(penable_s_o), .PWRITE_S(pwrite_s_o),
        .PADDR_S(paddr_s_o), .PWDATA_S(pwdata_s_o), .PSTRB_S(pstrb_s_o),
        .PRDATA_S(prdata_s), .PREADY_S(pready_s), .PSLVERR_S(pslverr_s),
        .err_pulse(err_pulse_o), .err_cause(err_cause_o),
        .err_count(err_count_o), .last_err_addr(last_err_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Address map as plain arithmetic: 4 KB slots from 0x1000.
    function automatic bit is_mapped(input logic [31:0] a);
        return (a >= 32'h1000) && (((a - 32'h1000) / 32'h1000) < NS);
    endfunction

    function automatic int slot_of(input logic [31:0] a);
        return int'((a - 32'h1000) / 32'h1000);
    endfunction

    // Reference model: transfer context plus the error record.
    bit          m_active = 1'b0, n_active = 1'b0;
    logic [31:0] m_addr = '0, n_addr = '0;
    int          m_wait = 0, n_wait = 0;
    bit          m_pulse = 1'b0, n_pulse = 1'b0;
    logic [1:0]  m_cause = '0, n_cause = '0;
    int          m_count = 0, n_count = 0;
    logic [31:0] m_last = '0, n_last = '0;

    always @(negedge clk) begin
        logic [3:0]  e_sel;
        logic        e_rdy, e_err, ev;
        logic [31:0] e_rd;
        logic [1:0]  ev_cause;
        int          s;
        e_sel = '0; e_rdy = 1'b0; e_err = 1'b0; e_rd = '0; ev = 1'b0; ev_cause = '0;
        n_active = m_active; n_addr = m_addr; n_wait = m_wait;
        if (rst !== 1'b1) begin
            n_active = 1'b0; n_wait = 0;
        end else if (!m_active) begin
            if (psel && !penable) begin
                if (is_mapped(paddr)) e_sel = 4'(1 << slot_of(paddr));
                n_active = 1'b1; n_addr = paddr; n_wait = 0;
            end else if (psel && penable) begin
                e_rdy = 1'b1; e_err = 1'b1; ev = 1'b1; ev_cause = 2'd3;
            end
        end else if (!psel) begin
            n_active = 1'b0;
        end else begin
            s = slot_of(m_addr);
            if (is_mapped(m_addr)) e_sel = 4'(1 << s);
            if (penable) begin
                if (!is_mapped(m_addr)) begin
                    e_rdy = 1'b1; e_err = 1'b1; ev = 1'b1; ev_cause = 2'd1; n_active = 1'b0;
                end else if (pready_s[s]) begin
                    e_rdy = 1'b1; e_err = pslverr_s[s]; e_rd = prdata_s[s*32 +: 32]; n_active = 1'b0;
                end else if (m_wait == TMO) begin
                    e_rdy = 1'b1; e_err = 1'b1; ev = 1'b1; ev_cause = 2'd2; n_active = 1'b0;
                end else begin
                    n_wait = m_wait + 1;
                end
            end
        end

        if (checking) begin
            chk("m_psel_s", 32'(psel_s_o), 32'(e_sel));
            chk("m_pready", 32'(pready_o), 32'(e_rdy));
            chk("m_pslverr", 32'(pslverr_o), 32'(e_err));
            chk("m_prdata", prdata_o, e_rd);
            chk("m_fanout", {pwdata_s_o[22:0], pstrb_s_o, pwrite_s_o, penable_s_o, 3'b0},
                {pwdata[22:0], pstrb, pwrite, penable, 3'b0});
            chk("m_paddr_s", paddr_s_o, paddr);
            chk("m_err_pulse", 32'(err_pulse_o), 32'(m_pulse));
            chk("m_err_cause", 32'(err_cause_o), 32'(m_cause));
            chk("m_err_count", 32'(err_count_o), 32'(m_count));
            chk("m_last_err_addr", last_err_addr_o, m_last);
        end

        n_cause = m_cause; n_count = m_count; n_last = m_last;
        if (rst !== 1'b1) begin
            n_pulse = 1'b0; n_cause = '0; n_count = 0; n_last = '0;
        end else begin
            n_pulse = ev;
            if (ev) begin
                n_cause = ev_cause;
                n_count = (m_count < 255) ? m_count + 1 : 255;
                n_last  = paddr;
            end
        end
    end

    always @(posedge clk) begin
        m_active = n_active; m_addr = n_addr; m_wait = n_wait;
        m_pulse = n_pulse; m_cause = n_cause; m_count = n_count; m_last = n_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer; the addressed slave answers after `waits` ACCESS cycles (-1: never).
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                        input int slot, input int waits, input bit serr,
                        output logic [3:0] setup_sel, output logic [3:0] acc_sel,
                        output logic [31:0] rdata, output bit err, output int ncyc);
        bit done;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = 4'hF;
        pready_s = '0; pslverr_s = '0;
        rdata = '0; err = 1'b0; ncyc = 0; done = 1'b0; acc_sel = '0;
        @(negedge clk);
        setup_sel = psel_s_o;
        step();
        penable = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            pready_s  = (waits >= 0 && k >= waits) ? 4'(1 << slot) : 4'b0;
            pslverr_s = serr ? pready_s : 4'b0;
            @(negedge clk);
            if (k == 0) acc_sel = psel_s_o;
            if (pready_o === 1'b1) begin
                done = 1'b1; ncyc = k + 1; rdata = prdata_o; err = pslverr_o;
            end
            step();
        end
        psel = 1'b0; penable = 1'b0; pready_s = '0; pslverr_s = '0;
        if (!done) chk("xfer_completion_bound", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ss, as;
        logic [31:0] rd;
        bit          er;
        int          nc;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        checking = 1'b1;
        @(negedge clk);
        chk("reset_pready", 32'(pready_o), 32'd0);
        chk("reset_psel_s", 32'(psel_s_o), 32'd0);
        chk("reset_err_count", 32'(err_count_o), 32'd0);
        chk("reset_err_cause", 32'(err_cause_o), 32'd0);
        step();

        xfer(32'h1000, 1'b1, 32'hA5, 0, 0, 1'b0, ss, as, rd, er, nc);
        chk("wr1000_setup_sel", 32'(ss), 32'b0001);
        chk("wr1000_access_sel", 32'(as), 32'b0001);
        chk("wr1000_cycles", nc, 1);
        chk("wr1000_pslverr", 32'(er), 32'd0);

        xfer(32'h3004, 1'b0, 32'h0, 2, 3, 1'b0, ss, as, rd, er, nc);
        chk("rd3004_setup_sel", 32'(ss), 32'b0100);
        chk("rd3004_rdata", rd, 32'hDEADBEEF);
        chk("rd3004_cycles", nc, 4);

        xfer(32'h4FFC, 1'b0, 32'h0, 3, 0, 1'b0, ss, as, rd, er, nc);
        chk("rd4ffc_setup_sel", 32'(ss), 32'b1000);
        chk("rd4ffc_rdata", rd, 32'h33330003);

        xfer(32'h5000, 1'b0, 32'h0, 0, -1, 1'b0, ss, as, rd, er, nc);
        chk("unm5000_setup_sel", 32'(ss), 32'b0000);
        chk("unm5000_access_sel", 32'(as), 32'b0000);
        chk("unm5000_cycles", nc, 1);
        chk("unm5000_pslverr", 32'(er), 32'd1);
        chk("unm5000_rdata", rd, 32'h0);
        @(negedge clk);
        chk("unm5000_err_pulse", 32'(err_pulse_o), 32'd1);
        chk("unm5000_err_cause", 32'(err_cause_o), 32'd1);
        chk("unm5000_err_count", 32'(err_count_o), 32'd1);
        chk("unm5000_last_addr", last_err_addr_o, 32'h5000);
        step();

        xfer(32'h0FFC, 1'b0, 32'h0, 0, -1, 1'b0, ss, as, rd, er, nc);
        chk("unm0ffc_setup_sel", 32'(ss), 32'b0000);
        chk("unm0ffc_pslverr", 32'(er), 32'd1);
        @(negedge clk);
        chk("unm0ffc_err_count", 32'(err_count_o), 32'd2);
        step();

        xfer(32'h2000, 1'b0, 32'h0, 1, -1, 1'b0, ss, as, rd, er, nc);
        chk("tmo_cycles", nc, 17);
        chk("tmo_pslverr", 32'(er), 32'd1);
        chk("tmo_rdata", rd, 32'h0);
        @(negedge clk);
        chk("tmo_err_cause", 32'(err_cause_o), 32'd2);
        chk("tmo_err_count", 32'(err_count_o), 32'd3);
        chk("tmo_last_addr", last_err_addr_o, 32'h2000);
        step();

        xfer(32'h2000, 1'b0, 32'h0, 1, 16, 1'b0, ss, as, rd, er, nc);
        chk("tmo_rescue_cycles", nc, 17);
        chk("tmo_rescue_pslverr", 32'(er), 32'd0);
        chk("tmo_rescue_rdata", rd, 32'h11110001);
        @(negedge clk);
        chk("tmo_rescue_err_pulse", 32'(err_pulse_o), 32'd0);
        chk("tmo_rescue_err_count", 32'(err_count_o), 32'd3);
        step();

        xfer(32'h1008, 1'b1, 32'h5A5A, 0, 1, 1'b1, ss, as, rd, er, nc);
        chk("slverr_pass_pslverr", 32'(er), 32'd1);
        chk("slverr_pass_cycles", nc, 2);
        @(negedge clk);
        chk("slverr_pass_err_count", 32'(err_count_o), 32'd3);
        step();

        psel = 1'b1; penable = 1'b1; paddr = 32'h1234;
        @(negedge clk);
        chk("proto_pready", 32'(pready_o), 32'd1);
        chk("proto_pslverr", 32'(pslverr_o), 32'd1);
        chk("proto_psel_s", 32'(psel_s_o), 32'd0);
        step();
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("proto_err_pulse", 32'(err_pulse_o), 32'd1);
        chk("proto_err_cause", 32'(err_cause_o), 32'd3);
        chk("proto_err_count", 32'(err_count_o), 32'd4);
        chk("proto_last_addr", last_err_addr_o, 32'h1234);
        step();

        psel = 1'b1; penable = 1'b0; paddr = 32'h2000;
        step();
        penable = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0;
        step();
        @(negedge clk);
        chk("abort_err_count", 32'(err_count_o), 32'd4);
        chk("abort_err_pulse", 32'(err_pulse_o), 32'd0);
        step();

        psel = 1'b1; penable = 1'b1; paddr = 32'h9000;
        repeat (300) step();
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("sat_err_count", 32'(err_count_o), 32'hFF);
        chk("sat_last_addr", last_err_addr_o, 32'h9000);
        step();

        psel = 1'b1; penable = 1'b0; paddr = 32'h2000; pready_s = '0;
        step();
        penable = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hold_psel_s", 32'(psel_s_o), 32'd0);
        step();
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("rst_after_pready", 32'(pready_o), 32'd0);
        chk("rst_after_psel_s", 32'(psel_s_o), 32'd0);
        chk("rst_after_err_count", 32'(err_count_o), 32'd0);
        chk("rst_after_err_cause", 32'(err_cause_o), 32'd0);
        chk("rst_after_last_addr", last_err_addr_o, 32'h0);
        step();

        xfer(32'h1000, 1'b0, 32'h0, 0, 0, 1'b0, ss, as, rd, er, nc);
        chk("post_rst_setup_sel", 32'(ss), 32'b0001);
        chk("post_rst_cycles", nc, 1);
        chk("post_rst_rdata", rd, 32'h00A500A5);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
